sram_port_arbiter: RTL and testbench

- Shares the single SRAM-like memory port between the fetch requester (read-only) and the load/store requester.
- Each requester has its own req/addr_ok/data_ok handshake.
- Sits between the fetch and execute/memory stages and the downstream SRAM or bridge.
- Tracks outstanding transactions in order and routes each response back to the requester that issued it.

---
 rtl/sram_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch and load/store requesters,
// routing in-order responses back by owner id. Define ARB_ROUND_ROBIN_EN for alternating grant on contention.
module sram_port_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  localparam int               PTR_W    = CNT_W - 1;
  localparam logic             OWN_INST = 1'b0;
  localparam logic             OWN_DATA = 1'b1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

  logic                   lock_valid_r;
  logic                   lock_owner_r;
  logic [OUTSTANDING-1:0] owner_fifo_r;
  logic [PTR_W-1:0]       head_r;
  logic [PTR_W-1:0]       tail_r;
  logic [CNT_W-1:0]       count_r;
  logic                   arb_err_r;

  logic full_s;
  logic empty_s;
  logic grant_s;
  logic contend_pick_s;
  logic mem_req_s;
  logic accept_s;
  logic pop_s;
  logic head_owner_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_winner_r;

  // On contention, favour whoever did not win the latest acceptance
  always_comb begin
    contend_pick_s = ~last_winner_r;
  end

  // Remember the most recent acceptance winner
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_r <= OWN_INST;
    end else if (accept_s) begin
      last_winner_r <= grant_s;
    end else begin
      last_winner_r <= last_winner_r;
    end
  end
`else
  // Fixed priority: load/store beats fetch on contention
  always_comb begin
    contend_pick_s = OWN_DATA;
  end
`endif

  // Grant selection, occupancy flags and handshake strobes
  always_comb begin
    full_s  = (count_r == CNT_FULL);
    empty_s = (count_r == {CNT_W{1'b0}});
    grant_s = OWN_INST;
    if (lock_valid_r) begin
      grant_s = lock_owner_r;
    end else if (inst_req && data_req) begin
      grant_s = contend_pick_s;
    end else if (data_req) begin
      grant_s = OWN_DATA;
    end else begin
      grant_s = OWN_INST;
    end
    mem_req_s    = (lock_valid_r | inst_req | data_req) & ~full_s;
    accept_s     = mem_req_s & mem_addr_ok;
    pop_s        = mem_data_ok & ~empty_s;
    head_owner_s = owner_fifo_r[head_r];
  end

  // Memory-side request mux; payload is zero whenever no request is presented
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (mem_req_s) begin
      if (grant_s == OWN_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_size  = 2'd2;
        mem_addr  = inst_addr;
      end
    end else begin
      mem_wr    = 1'b0;
    end
  end

  assign mem_req      = mem_req_s;
  assign inst_addr_ok = accept_s & (grant_s == OWN_INST);
  assign data_addr_ok = accept_s & (grant_s == OWN_DATA);
  assign inst_data_ok = pop_s & (head_owner_s == OWN_INST);
  assign data_data_ok = pop_s & (head_owner_s == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign arb_err      = arb_err_r;

  // Lock, owner FIFO, occupancy count and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_r <= 1'b0;
      lock_owner_r <= OWN_INST;
      owner_fifo_r <= {OUTSTANDING{1'b0}};
      head_r       <= {PTR_W{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      arb_err_r    <= 1'b0;
    end else begin
      // Hold the grant until the memory takes it so mem_* stays stable
      if (mem_req_s && !mem_addr_ok) begin
        lock_valid_r <= 1'b1;
        lock_owner_r <= grant_s;
      end else if (accept_s) begin
        lock_valid_r <= 1'b0;
      end else begin
        lock_valid_r <= lock_valid_r;
      end
      if (accept_s) begin
        owner_fifo_r[tail_r] <= grant_s;
        tail_r               <= tail_r + PTR_ONE;
      end else begin
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end else begin
        head_r <= head_r;
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (mem_data_ok && empty_s) begin
        arb_err_r <= 1'b1;
      end else begin
        arb_err_r <= arb_err_r;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed bench for sram_port_arbiter against a queue-based ownership model.
module tb_sram_port_arbiter;
  localparam int OUTSTANDING = 4;
  localparam int CNT_W       = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  always #5 clk = ~clk;

  sram_port_arbiter #(.OUTSTANDING(OUTSTANDING), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: owners of accepted-but-unanswered transactions, oldest first
  bit q[$];
  bit lk_valid = 1'b0, lk_owner = 1'b0, last_win = 1'b0, m_err = 1'b0, model_on = 1'b0;
  bit e_grant, e_mem_req, e_acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit full;
    full = (q.size() == OUTSTANDING);
    if (lk_valid) e_grant = lk_owner;
    else if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      e_grant = ~last_win;
`else
      e_grant = 1'b1;
`endif
    end else e_grant = data_req;
    e_mem_req = (lk_valid || inst_req || data_req) && !full;
    e_acc     = e_mem_req && mem_addr_ok;
  endtask

  task automatic compare();
    bit pop;
    model_eval();
    if (!model_on) return;
    pop = mem_data_ok && (q.size() > 0);
    chk("mem_req", mem_req, e_mem_req);
    if (!e_mem_req) begin
      chk("mem_wr", mem_wr, 0);       chk("mem_size", mem_size, 0);
      chk("mem_wstrb", mem_wstrb, 0); chk("mem_addr", mem_addr, 0);
      chk("mem_wdata", mem_wdata, 0);
    end else if (e_grant) begin
      chk("mem_wr", mem_wr, data_wr);          chk("mem_size", mem_size, data_size);
      chk("mem_wstrb", mem_wstrb, data_wstrb); chk("mem_addr", mem_addr, data_addr);
      chk("mem_wdata", mem_wdata, data_wdata);
    end else begin
      chk("mem_wr", mem_wr, 0);       chk("mem_size", mem_size, 2);
      chk("mem_wstrb", mem_wstrb, 0); chk("mem_addr", mem_addr, inst_addr);
      chk("mem_wdata", mem_wdata, 0);
    end
    chk("inst_addr_ok", inst_addr_ok, e_acc && !e_grant);
    chk("data_addr_ok", data_addr_ok, e_acc && e_grant);
    chk("inst_data_ok", inst_data_ok, pop && (q[0] == 1'b0));
    chk("data_data_ok", data_data_ok, pop && (q[0] == 1'b1));
    chk("inst_rdata", inst_rdata, mem_rdata);
    chk("data_rdata", data_rdata, mem_rdata);
    chk("arb_err", arb_err, m_err);
  endtask

  task automatic settle();
    #1;
    compare();
  endtask

  task automatic adv();
    @(posedge clk);
    model_eval();
    if (reset) begin
      q.delete();
      lk_valid = 1'b0; last_win = 1'b0; m_err = 1'b0; model_on = 1'b1;
    end else begin
      if (mem_data_ok) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1'b1;
      end
      if (e_acc) begin
        q.push_back(e_grant);
        last_win = e_grant;
      end
      if (e_mem_req && !mem_addr_ok) begin
        lk_valid = 1'b1; lk_owner = e_grant;
      end else if (e_acc) lk_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic idle();
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic drain(input int n);
    mem_data_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_rdata = $urandom;
      cyc();
    end
    mem_data_ok = 1'b0;
  endtask

  initial begin
    bit acc_i, acc_d, rst_now;
    idle();
    reset = 1'b1;
    @(negedge clk);
    adv();
    cyc();
    reset = 1'b0;
    settle();
    chk("reset_mem_req", mem_req, 0);
    chk("reset_arb_err", arb_err, 0);
    chk("reset_mem_size", mem_size, 0);
    adv();

    // Single fetch with two-cycle read latency
    inst_req = 1'b1; inst_addr = 32'hBFC00000; mem_addr_ok = 1'b1;
    settle();
    chk("tp_inst_aok", inst_addr_ok, 1);
    chk("tp_inst_maddr", mem_addr, 32'hBFC00000);
    adv();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    cyc();
    mem_data_ok = 1'b1; mem_rdata = 32'h3C1D0000;
    settle();
    chk("tp_inst_dok", inst_data_ok, 1);
    chk("tp_inst_rdata", inst_rdata, 32'h3C1D0000);
    chk("tp_inst_data_silent", data_data_ok, 0);
    adv();
    mem_data_ok = 1'b0;

    // Contention: store wins first, fetch next cycle
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'b0011;
    data_addr = 32'h80001000; data_wdata = 32'hCAFEF00D; mem_addr_ok = 1'b1;
    settle();
    chk("cont_data_aok", data_addr_ok, 1);
    chk("cont_inst_wait", inst_addr_ok, 0);
    chk("cont_mem_wr", mem_wr, 1);
    chk("cont_mem_wstrb", mem_wstrb, 4'b0011);
    adv();
    data_req = 1'b0; data_wr = 1'b0;
    settle();
    chk("cont_inst_aok", inst_addr_ok, 1);
    adv();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    settle();
    chk("cont_first_resp_data", data_data_ok, 1);
    adv();
    settle();
    chk("cont_second_resp_inst", inst_data_ok, 1);
    adv();
    mem_data_ok = 1'b0;

    // Lock holds the load until the memory accepts it
    data_req = 1'b1; data_wstrb = 4'd0; data_addr = 32'h80001000;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) inst_req = 1'b1;
      settle();
      chk("lock_maddr", mem_addr, 32'h80001000);
      adv();
    end
    mem_addr_ok = 1'b1;
    settle();
    chk("lock_data_aok", data_addr_ok, 1);
    chk("lock_inst_wait", inst_addr_ok, 0);
    adv();
    data_req = 1'b0;
    settle();
    chk("lock_inst_aok", inst_addr_ok, 1);
    adv();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    drain(2);

    // Fill to capacity, then pop and accept in the same cycle
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'h1000 + 32'(i * 4);
      cyc();
    end
    settle();
    chk("full_mem_req", mem_req, 0);
    adv();
    mem_data_ok = 1'b1; mem_rdata = 32'h11;
    settle();
    chk("full_pop_blocks_req", mem_req, 0);
    chk("full_rdata_11", inst_rdata, 32'h11);
    chk("full_dok_11", inst_data_ok, 1);
    adv();
    mem_rdata = 32'h22;
    settle();
    chk("cnt3_accept", inst_addr_ok, 1);
    chk("cnt3_pop", inst_data_ok, 1);
    adv();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    settle();
    adv();
    mem_data_ok = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      mem_rdata = 32'(i * 17);
      settle();
      chk("order_inst_dok", inst_data_ok, 1);
      adv();
    end
    mem_data_ok = 1'b0;

    // Mixed owners return in acceptance order
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    cyc();
    inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0;
    cyc();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'hAA;
    settle();
    chk("mix_inst_dok", inst_data_ok, 1);
    chk("mix_inst_rdata", inst_rdata, 32'hAA);
    adv();
    mem_rdata = 32'hBB;
    settle();
    chk("mix_data_dok", data_data_ok, 1);
    chk("mix_data_rdata", data_rdata, 32'hBB);
    chk("mix_inst_quiet", inst_data_ok, 0);
    adv();

    // Stray response sets the sticky error; reset clears it
    cyc();
    mem_data_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("err_sticky", arb_err, 1);
      adv();
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    chk("err_cleared", arb_err, 0);
    chk("err_reset_mem_req", mem_req, 0);
    adv();

    // Reset mid-flight discards ownership
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    cyc();
    inst_req = 1'b0; mem_addr_ok = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0; mem_data_ok = 1'b1;
    settle();
    chk("midrst_no_route", inst_data_ok, 0);
    adv();
    mem_data_ok = 1'b0;
    settle();
    chk("midrst_err", arb_err, 1);
    adv();
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // Random traffic with requesters holding until accepted
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] rnd;
      if (!inst_req && ($urandom_range(0, 1) == 1)) begin
        inst_req = 1'b1; rnd = $urandom; inst_addr = {rnd[31:2], 2'b00};
      end
      if (!data_req && ($urandom_range(0, 1) == 1)) begin
        rnd = $urandom;
        data_req = 1'b1; data_wr = rnd[0]; data_wstrb = rnd[7:4];
        data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom; data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      reset = ($urandom_range(0, 499) == 0);
      rst_now = reset;
      settle();
      acc_i = e_acc && !e_grant;
      acc_d = e_acc && e_grant;
      adv();
      if (acc_i || rst_now) inst_req = 1'b0;
      if (acc_d || rst_now) data_req = 1'b0;
      reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
